lfsr_sched: RTL

Round-robin scheduler that shares one 4-bit LFSR instance between two requesters. Each requester supplies a seed and asks for a word of pseudo-random bits. The block loads the granted seed into the LFSR, collects WORD_W serial output bits into a word, and returns the word with a one-cycle acknowledge. It sits between the LFSR and its consumers and owns the LFSR's seed and reset pins.

---
 rtl/lfsr_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one 4-bit LFSR between two requesters.
// A granted request loads its seed into the LFSR, collects WORD_W serial bits
// (first bit lands in the MSB) and returns the word with a one-cycle ack.
// A request that sees TIMEOUT consecutive invalid cycles is aborted with rsp_err_o.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   req0_i/req1_i  level requests, held until the matching ack
//   seed0_i/1_i    per-requester seed, sampled at grant
//   ack0_o/ack1_o  one-cycle completion pulses
//   rsp_data_o     collected word, valid while an ack is high
//   rsp_err_o      high with the ack when the request timed out
//   busy_o         high in LOAD, RUN, DONE
//   lfsr_seed_o    seed to the LFSR
//   lfsr_reset_o   active-low LFSR reset (low = load seed / hold)
//   lfsr_out_i     LFSR serial bit
//   lfsr_valid_i   lfsr_out_i is meaningful this cycle
module lfsr_sched #(
   parameter int unsigned WORD_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic [3:0]        seed0_i,
   input  logic [3:0]        seed1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [WORD_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic [3:0]        lfsr_seed_o,
   output logic              lfsr_reset_o,
   input  logic              lfsr_out_i,
   input  logic              lfsr_valid_i
);

   localparam int unsigned CntW  = $clog2(WORD_W + 1);
   localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0]  CntLast  = CntW'(WORD_W - 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e            state_q;
   logic              id_q;
   logic              last_q;
   logic [CntW-1:0]   count_q;
   logic [IdleW-1:0]  idle_q;
   logic [WORD_W-1:0] word_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [WORD_W-1:0] rsp_data_q;
   logic              rsp_err_q;
   logic [3:0]        lfsr_seed_q;
   logic              lfsr_reset_q;

   logic              grant_id;
   logic [3:0]        grant_seed;
   logic [WORD_W-1:0] word_shift;

   // On a tie the requester not granted last wins.
   always_comb begin
      grant_id = req1_i;
      if (req0_i && req1_i) begin
         grant_id = ~last_q;
      end
      grant_seed = grant_id ? seed1_i : seed0_i;
      // An all-zero seed would lock the LFSR up.
      if (grant_seed == 4'b0000) begin
         grant_seed = 4'b0001;
      end
   end

   assign word_shift = {word_q[WORD_W-2:0], lfsr_out_i};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         id_q         <= 1'b0;
         last_q       <= 1'b1;
         count_q      <= '0;
         idle_q       <= '0;
         word_q       <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         lfsr_seed_q  <= 4'b0001;
         lfsr_reset_q <= 1'b0;
      end else begin
         // Response outputs are only non-zero during the single DONE cycle.
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req0_i || req1_i) begin
                  state_q     <= StLoad;
                  id_q        <= grant_id;
                  last_q      <= grant_id;
                  lfsr_seed_q <= grant_seed;
                  word_q      <= '0;
               end
            end
            StLoad: begin
               state_q      <= StRun;
               count_q      <= '0;
               idle_q       <= '0;
               lfsr_reset_q <= 1'b1;
            end
            StRun: begin
               if (lfsr_valid_i) begin
                  // A valid bit always wins over a coincident timeout.
                  word_q  <= word_shift;
                  count_q <= count_q + 1'b1;
                  idle_q  <= '0;
                  if (count_q == CntLast) begin
                     state_q      <= StDone;
                     lfsr_reset_q <= 1'b0;
                     ack0_q       <= ~id_q;
                     ack1_q       <= id_q;
                     rsp_data_q   <= word_shift;
                  end
               end else begin
                  idle_q <= idle_q + 1'b1;
                  if (idle_q == IdleLast) begin
                     state_q      <= StDone;
                     lfsr_reset_q <= 1'b0;
                     ack0_q       <= ~id_q;
                     ack1_q       <= id_q;
                     rsp_data_q   <= word_q;
                     rsp_err_q    <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q     <= StIdle;
               lfsr_seed_q <= 4'b0001;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ack0_o       = ack0_q;
   assign ack1_o       = ack1_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_err_o    = rsp_err_q;
   assign busy_o       = (state_q != StIdle);
   assign lfsr_seed_o  = lfsr_seed_q;
   assign lfsr_reset_o = lfsr_reset_q;

endmodule
